cla16_pipe_add: RTL

- Pipelined two's-complement adder/subtractor built from 4-bit carry-lookahead slices.
- Each slice produces its own sum, group propagate and group generate; a second-level lookahead combines the group signals.
- Sits directly downstream of the operand source and upstream of the result consumer, with a valid/ready handshake on both sides.
- Splits the addition across two register stages, low half then high half, to halve the carry path per cycle.

---
 rtl/cla16_pipe_add.sv | 91 +++++++++
 1 files changed

// File: rtl/cla16_pipe_add.sv
// cla16_pipe_add: three-stage add/sub built from 4-bit CLA slices, low half then high half.
module cla16_pipe_add #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int H = WIDTH / 2;
  logic             adv;
  logic             v1, c1, v2, cm2, v3, co3, ov3, z3;
  logic [WIDTH-1:0] a1, b1, s3;
  logic [H-1:0]     s2, ah2, bh2;
  logic [H:0]       lo, hi;
  // Returns {carry out, sum}; each slice yields group P/G, combined by a second-level lookahead.
  function automatic logic [H:0] cla_add(input logic [H-1:0] a, input logic [H-1:0] b, input logic ci);
    logic [H-1:0] p, g;
    logic [H:0]   c;
    logic [H/4:0] gc;
    logic         gp, gg;
    p = a ^ b;
    g = a & b;
    c = '0;
    gc = '0;
    gc[0] = ci;
    for (int k = 0; k < H / 4; k++) begin
      gp = &p[4*k +: 4];
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gc[k+1] = gg | (gp & gc[k]);
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    c[H] = gc[H/4];
    return {c[H], p ^ c[H-1:0]};
  endfunction
  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign lo        = cla_add(a1[H-1:0], b1[H-1:0], c1);
  assign hi        = cla_add(ah2, bh2, cm2);
  assign out_valid = v3;
  assign out_sum   = s3;
  assign out_cout  = co3;
  assign out_ovf   = ov3;
  assign out_zero  = z3;
  // Data registers only load behind a valid beat, so idle inputs never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, c1, v2, cm2, v3, co3, ov3, z3} <= '0;
      a1  <= '0;
      b1  <= '0;
      s2  <= '0;
      ah2 <= '0;
      bh2 <= '0;
      s3  <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        a1 <= in_op1;
        b1 <= in_sub ? ~in_op2 : in_op2;
        c1 <= in_sub | in_cin;
      end
      if (v1) begin
        s2  <= lo[H-1:0];
        cm2 <= lo[H];
        ah2 <= a1[WIDTH-1:H];
        bh2 <= b1[WIDTH-1:H];
      end
      if (v2) begin
        s3  <= {hi[H-1:0], s2};
        co3 <= hi[H];
        // carry into the MSB recovered from the MSB sum and operand bits
        ov3 <= hi[H] ^ (hi[H-1] ^ ah2[H-1] ^ bh2[H-1]);
        z3  <= ~|{hi[H-1:0], s2};
      end
    end
  end
endmodule
